// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck core and its memory arbiter:
// arbiter FSM states, unified-address region selects, instruction characters.
package bf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CORE_WAIT,
    ST_CORE_DONE,
    ST_HOST_WAIT
  } arb_state_t;

  // MSB of the unified RAM address selects the region.
  localparam logic REGION_PROG = 1'b0;
  localparam logic REGION_DATA = 1'b1;

  // Instruction characters as stored in the program region.
  localparam logic [7:0] CH_INC        = 8'h2B;  // '+'
  localparam logic [7:0] CH_DEC        = 8'h2D;  // '-'
  localparam logic [7:0] CH_RIGHT      = 8'h3E;  // '>'
  localparam logic [7:0] CH_LEFT       = 8'h3C;  // '<'
  localparam logic [7:0] CH_OUT        = 8'h2E;  // '.'
  localparam logic [7:0] CH_IN         = 8'h2C;  // ','
  localparam logic [7:0] CH_LOOP_OPEN  = 8'h5B;  // '['
  localparam logic [7:0] CH_LOOP_CLOSE = 8'h5D;  // ']'

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bf_wait_counter.sv
// Saturating counter: counts host arbitration losses, cleared when the host
// is granted; at_max tells the arbiter the host must win the next slot.
module bf_wait_counter #(
  parameter int MAX = 4,
  localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [CW-1:0] r_cnt;

  assign at_max = (r_cnt == CW'(MAX));

  // Count losses up to MAX, clear on grant or reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (inc && !at_max) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bf_mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM (1-cycle read latency)
// between the core program port, the core data port and a host port.
// Build option: define BF_MEM_PROTECT_EN to block host writes into the
// program region while the core runs (adds the sticky host_err output).
module bf_mem_arbiter
  import bf_pkg::*;
#(
  parameter int PROG_ADDR_WIDTH = 8,
  parameter int DATA_ADDR_WIDTH = 8,
  parameter int VALUE_WIDTH     = 8,
  parameter int HOST_MAX_WAIT   = 4,
  localparam int MEM_ADDR_WIDTH = max_int(PROG_ADDR_WIDTH, DATA_ADDR_WIDTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  output logic                       core_en,
  input  logic [PROG_ADDR_WIDTH-1:0] prog_addr,
  input  logic                       prog_ren,
  output logic [VALUE_WIDTH-1:0]     prog_rval,
  input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
  input  logic                       data_ren,
  input  logic                       data_wen,
  input  logic [VALUE_WIDTH-1:0]     data_wval,
  output logic [VALUE_WIDTH-1:0]     data_rval,
  input  logic                       host_req,
  input  logic                       host_we,
  input  logic [MEM_ADDR_WIDTH-1:0]  host_addr,
  input  logic [VALUE_WIDTH-1:0]     host_wdata,
  output logic                       host_gnt,
  output logic                       host_rvalid,
  output logic [VALUE_WIDTH-1:0]     host_rdata,
`ifdef BF_MEM_PROTECT_EN
  output logic                       host_err,
`endif
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
  output logic [VALUE_WIDTH-1:0]     mem_wdata,
  input  logic [VALUE_WIDTH-1:0]     mem_rdata
);

  localparam int BODY_W = MEM_ADDR_WIDTH - 1;

  arb_state_t           r_state;
  logic [VALUE_WIDTH-1:0] r_prog_rval;
  logic [VALUE_WIDTH-1:0] r_data_rval;
  logic [VALUE_WIDTH-1:0] r_host_rdata;
  logic                 r_rd_is_data;

  logic w_idle;
  logic w_at_max;
  logic w_core_rd;
  logic w_core_wr;
  logic w_gnt_host;
  logic w_gnt_rd;
  logic w_gnt_wr;
  logic w_wait_inc;
  logic w_host_blocked;

  // Arbitration only happens in IDLE and never while reset is asserted.
  assign w_idle    = (r_state == ST_IDLE) && !reset;
  // Core strobes only count while the host lets the core run.
  assign w_core_rd = run && (data_ren || prog_ren);
  assign w_core_wr = run && data_wen;

`ifdef BF_MEM_PROTECT_EN
  assign w_host_blocked = host_we && (host_addr[MEM_ADDR_WIDTH-1] == REGION_PROG) && run;
`else
  assign w_host_blocked = 1'b0;
`endif

  // Pick this cycle's RAM owner: forced host, core read, core write, idle host.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_gnt_host = 1'b0;
    w_gnt_rd   = 1'b0;
    w_gnt_wr   = 1'b0;
    if (w_idle) begin
      if (host_req && (w_at_max || !run)) begin
        w_gnt_host = 1'b1;
      end else if (w_core_rd) begin
        w_gnt_rd = 1'b1;
      end else if (w_core_wr) begin
        w_gnt_wr = 1'b1;
      end else if (host_req) begin
        w_gnt_host = 1'b1;
      end
    end
  end

  assign w_wait_inc = w_idle && host_req && !w_gnt_host;

  bf_wait_counter #(
    .MAX (HOST_MAX_WAIT)
  ) u_wait_counter (
    .clk    (clk),
    .reset  (reset),
    .inc    (w_wait_inc),
    .clr    (w_gnt_host),
    .at_max (w_at_max)
  );

  // Drive the RAM port from the granted requester; unused address bits stay zero.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt_host) begin
      mem_en    = 1'b1;
      mem_we    = host_we && !w_host_blocked;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (w_gnt_rd) begin
      mem_en   = 1'b1;
      mem_addr = data_ren ? {REGION_DATA, BODY_W'(data_addr)}
                          : {REGION_PROG, BODY_W'(prog_addr)};
    end else if (w_gnt_wr) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {REGION_DATA, BODY_W'(data_addr)};
      mem_wdata = data_wval;
    end
  end

  // Core advances when idle and not stalled by a read or host grant, or when
  // its read data has just been latched.
  assign core_en = !reset && run &&
                   (((r_state == ST_IDLE) && !w_gnt_rd && !w_gnt_host) ||
                    (r_state == ST_CORE_DONE));

  assign host_gnt    = w_gnt_host;
  assign host_rvalid = !reset && (r_state == ST_HOST_WAIT);
  // RAM data arrives in the rvalid cycle; the register keeps it afterwards.
  assign host_rdata  = host_rvalid ? mem_rdata : r_host_rdata;
  assign prog_rval   = r_prog_rval;
  assign data_rval   = r_data_rval;

  // Access sequencer: tracks outstanding reads and captures RAM read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_prog_rval  <= '0;
      r_data_rval  <= '0;
      r_host_rdata <= '0;
      r_rd_is_data <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_rd) begin
            r_state      <= ST_CORE_WAIT;
            r_rd_is_data <= data_ren;
          end else if (w_gnt_host && !host_we) begin
            r_state <= ST_HOST_WAIT;
          end
        end
        ST_CORE_WAIT: begin
          if (r_rd_is_data) begin
            r_data_rval <= mem_rdata;
          end else begin
            r_prog_rval <= mem_rdata;
          end
          r_state <= ST_CORE_DONE;
        end
        ST_CORE_DONE: begin
          r_state <= ST_IDLE;
        end
        ST_HOST_WAIT: begin
          r_host_rdata <= mem_rdata;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef BF_MEM_PROTECT_EN
  // Sticky flag for a blocked host write into the program region.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_err <= 1'b0;
    end else if (w_gnt_host && w_host_blocked) begin
      host_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bf_mem_arbiter.sv
// Self-checking bench for bf_mem_arbiter: arbitration vector table, directed
// multi-cycle sequences and a randomized core/host run against a memory model.
`timescale 1ns/1ps
module tb_bf_mem_arbiter;

  localparam int HMW = 4;

`ifdef BF_MEM_PROTECT_EN
  localparam logic PROT_WE = 1'b0;
`else
  localparam logic PROT_WE = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       reset, run, core_en;
  logic [7:0] prog_addr, prog_rval, data_addr, data_wval, data_rval;
  logic       prog_ren, data_ren, data_wen;
  logic       host_req, host_we, host_gnt, host_rvalid;
  logic [8:0] host_addr, mem_addr;
  logic [7:0] host_wdata, host_rdata, mem_wdata, mem_rdata;
  logic       mem_en, mem_we;
`ifdef BF_MEM_PROTECT_EN
  logic       host_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  bf_mem_arbiter #(
    .PROG_ADDR_WIDTH (8),
    .DATA_ADDR_WIDTH (8),
    .VALUE_WIDTH     (8),
    .HOST_MAX_WAIT   (HMW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .core_en     (core_en),
    .prog_addr   (prog_addr),
    .prog_ren    (prog_ren),
    .prog_rval   (prog_rval),
    .data_addr   (data_addr),
    .data_ren    (data_ren),
    .data_wen    (data_wen),
    .data_wval   (data_wval),
    .data_rval   (data_rval),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
`ifdef BF_MEM_PROTECT_EN
    .host_err    (host_err),
`endif
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, one cycle read latency.
  logic [7:0] ram [0:511];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    prog_ren = 1'b0; data_ren = 1'b0; data_wen = 1'b0;
    prog_addr = 8'h00; data_addr = 8'h00; data_wval = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_addr = 9'h000; host_wdata = 8'h00;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    run = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Host write with run low; leaves the bench one cycle after the grant.
  task automatic host_write(input logic [8:0] a, input logic [7:0] d);
    logic got;
    got = 1'b0;
    tick();
    run = 1'b0; host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (host_gnt) got = 1'b1;
      else tick();
    end
    check("host_wr_gnt", 32'(got), 1);
    tick();
    host_req = 1'b0; host_we = 1'b0;
  endtask

  typedef struct {
    logic       run, pren, dren, dwen, hreq, hwe;
    logic [7:0] paddr, daddr;
    logic [8:0] haddr;
    logic [7:0] wval, hwdata;
    logic       e_core_en, e_gnt, e_mem_en, e_mem_we;
    logic [8:0] e_addr;
    logic [7:0] e_wdata;
  } vec_t;

  vec_t vecs [15];

  // Randomized-phase state.
  logic [7:0] ref_mem [0:511];
  logic       op_active, h_pending, exp_rv;
  int         op_kind, h_wait, ops_done, h_done;
  logic [7:0] op_paddr, op_daddr, op_wval, exp_rd, h_wdata;
  logic [8:0] h_addr;
  logic       h_we;
  logic       gnt_seen;
  int         losses;

  initial begin
    //                run   pren  dren  dwen  hreq  hwe   paddr  daddr  haddr   wval   hwdata  core  gnt   en    we    addr    wdata
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 9'h000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 9'h000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00, 9'h000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9'h005, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h7F, 9'h000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9'h17F, 8'h00};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 8'h33, 9'h000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9'h133, 8'h00};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 9'h000, 8'h41, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 9'h103, 8'h41};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 9'h103, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 9'h103, 8'h00};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 9'h1C0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9'h010, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h44, 9'h1C0, 8'h99, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 9'h144, 8'h99};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 9'h0AB, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 9'h0AB, 8'h00};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 9'h1AA, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 9'h1AA, 8'h5A};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 9'h010, 8'h00, 8'h77, 1'b0, 1'b1, 1'b1, PROT_WE, 9'h010, 8'h77};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00, 9'h000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 9'h000, 8'h41, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 8'h00, 9'h020, 8'h00, 8'h66, 1'b0, 1'b1, 1'b1, 1'b1, 9'h020, 8'h66};

    // ---- Reset with active stimulus ----
    reset = 1'b1;
    run = 1'b1;
    clear_inputs();
    prog_ren = 1'b1; host_req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_core_en", 32'(core_en), 0);
      check("rst_host_gnt", 32'(host_gnt), 0);
      check("rst_mem_en", 32'(mem_en), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_prog_rval", 32'(prog_rval), 0);
      check("rst_data_rval", 32'(data_rval), 0);
      check("rst_host_rvalid", 32'(host_rvalid), 0);
      check("rst_host_rdata", 32'(host_rdata), 0);
    end
    tick();
    reset = 1'b0;
    clear_inputs();

    // ---- Arbitration vector table, one reset per vector ----
    for (int i = 0; i < 15; i++) begin
      do_reset();
      tick();
      run = vecs[i].run; prog_ren = vecs[i].pren; data_ren = vecs[i].dren;
      data_wen = vecs[i].dwen; host_req = vecs[i].hreq; host_we = vecs[i].hwe;
      prog_addr = vecs[i].paddr; data_addr = vecs[i].daddr; host_addr = vecs[i].haddr;
      data_wval = vecs[i].wval; host_wdata = vecs[i].hwdata;
      @(negedge clk);
      check($sformatf("vec%0d_core_en", i), 32'(core_en), 32'(vecs[i].e_core_en));
      check($sformatf("vec%0d_host_gnt", i), 32'(host_gnt), 32'(vecs[i].e_gnt));
      check($sformatf("vec%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].e_mem_en));
      check($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_mem_we));
      if (vecs[i].e_mem_en)
        check($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      if (vecs[i].e_mem_we)
        check($sformatf("vec%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_wdata));
    end

    // ---- Program read latency: RAM[0x005]=0x2B ----
    do_reset();
    host_write(9'h005, 8'h2B);
    tick();
    run = 1'b1; prog_ren = 1'b1; prog_addr = 8'h05;
    @(negedge clk);
    check("pr_c0_core_en", 32'(core_en), 0);
    check("pr_c0_mem_addr", 32'(mem_addr), 32'h005);
    tick();
    @(negedge clk);
    check("pr_c1_core_en", 32'(core_en), 0);
    tick();
    @(negedge clk);
    check("pr_c2_core_en", 32'(core_en), 1);
    check("pr_prog_rval", 32'(prog_rval), 32'h2B);
    check("pr_data_rval_kept", 32'(data_rval), 0);

    // ---- Core data write, same-cycle ----
    tick();
    prog_ren = 1'b0; data_wen = 1'b1; data_addr = 8'h03; data_wval = 8'h41;
    @(negedge clk);
    check("dw_mem_we", 32'(mem_we), 1);
    check("dw_mem_addr", 32'(mem_addr), 32'h103);
    check("dw_mem_wdata", 32'(mem_wdata), 32'h41);
    check("dw_core_en", 32'(core_en), 1);

    // ---- Host read with run low ----
    tick();
    clear_inputs();
    run = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 9'h103;
    @(negedge clk);
    check("hr_gnt", 32'(host_gnt), 1);
    check("hr_mem_we", 32'(mem_we), 0);
    check("hr_core_en", 32'(core_en), 0);
    tick();
    host_req = 1'b0;
    @(negedge clk);
    check("hr_rvalid", 32'(host_rvalid), 1);
    check("hr_rdata", 32'(host_rdata), 32'h41);
    tick();
    @(negedge clk);
    check("hr_rvalid_drop", 32'(host_rvalid), 0);
    check("hr_rdata_held", 32'(host_rdata), 32'h41);
    check("hr_prog_rval_held", 32'(prog_rval), 32'h2B);

    // ---- Reset during an outstanding host read ----
    tick();
    run = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 9'h005;
    @(negedge clk);
    check("ra_gnt", 32'(host_gnt), 1);
    tick();
    host_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("ra_rvalid_in_reset", 32'(host_rvalid), 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("ra_rvalid_after", 32'(host_rvalid), 0);
    check("ra_rdata_cleared", 32'(host_rdata), 0);

    // ---- Host starvation bound under continuous core reads ----
    do_reset();
    tick();
    run = 1'b1; prog_ren = 1'b1; prog_addr = 8'h01;
    host_req = 1'b1; host_we = 1'b0; host_addr = 9'h101;
    gnt_seen = 1'b0;
    losses = 0;
    for (int c = 0; c < 40 && !gnt_seen; c++) begin
      @(negedge clk);
      if (host_gnt) gnt_seen = 1'b1;
      else if (mem_en) losses++;
      if (!gnt_seen) tick();
    end
    check("starve_gnt", 32'(gnt_seen), 1);
    check("starve_losses", 32'(losses), HMW);
    tick();
    clear_inputs();

`ifdef BF_MEM_PROTECT_EN
    // ---- Protected program region ----
    do_reset();
    @(negedge clk);
    check("prot_err_reset", 32'(host_err), 0);
    tick();
    run = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 9'h010; host_wdata = 8'h77;
    @(negedge clk);
    check("prot_gnt", 32'(host_gnt), 1);
    check("prot_mem_we", 32'(mem_we), 0);
    tick();
    clear_inputs();
    @(negedge clk);
    check("prot_err_set", 32'(host_err), 1);
    tick();
    tick();
    @(negedge clk);
    check("prot_err_sticky", 32'(host_err), 1);
`endif

    // ---- Randomized core/host traffic against a memory model ----
    do_reset();
    for (int a = 0; a < 8; a++) begin
      for (int r = 0; r < 2; r++) begin
        logic [8:0] ha;
        logic [7:0] v;
        ha = 9'(a);
        ha[8] = (r == 1);
        v = 8'($urandom_range(0, 255));
        host_write(ha, v);
        ref_mem[ha] = v;
      end
    end
    op_active = 1'b0; h_pending = 1'b0; exp_rv = 1'b0;
    op_kind = 0; h_wait = 0; ops_done = 0; h_done = 0;
    op_paddr = 8'h00; op_daddr = 8'h00; op_wval = 8'h00;
    h_addr = 9'h000; h_we = 1'b0; h_wdata = 8'h00; exp_rd = 8'h00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (!op_active && $urandom_range(0, 3) != 0) begin
        op_active = 1'b1;
        op_kind   = int'($urandom_range(0, 2));
        op_paddr  = 8'($urandom_range(0, 7));
        op_daddr  = 8'($urandom_range(0, 7));
        op_wval   = 8'($urandom_range(0, 255));
      end
      if (!h_pending && $urandom_range(0, 4) == 0) begin
        h_pending = 1'b1;
        h_wait    = 0;
        h_we      = ($urandom_range(0, 1) == 1);
        h_addr    = 9'($urandom_range(0, 7));
        h_addr[8] = ($urandom_range(0, 1) == 1);
        h_wdata   = 8'($urandom_range(0, 255));
      end
      run        = ($urandom_range(0, 9) != 0);
      prog_ren   = op_active && (op_kind == 0);
      data_ren   = op_active && (op_kind == 1);
      data_wen   = op_active && (op_kind == 2);
      prog_addr  = op_paddr;
      data_addr  = op_daddr;
      data_wval  = op_wval;
      host_req   = h_pending;
      host_we    = h_we;
      host_addr  = h_addr;
      host_wdata = h_wdata;
      @(negedge clk);
      if (!run) check("rnd_core_en_run0", 32'(core_en), 0);
      check("rnd_host_rvalid", 32'(host_rvalid), 32'(exp_rv));
      if (exp_rv) check("rnd_host_rdata", 32'(host_rdata), 32'(exp_rd));
      exp_rv = 1'b0;
      if (op_active && core_en) begin
        case (op_kind)
          0: check("rnd_prog_rval", 32'(prog_rval), 32'(ref_mem[{1'b0, op_paddr}]));
          1: check("rnd_data_rval", 32'(data_rval), 32'(ref_mem[{1'b1, op_daddr}]));
          default: ref_mem[{1'b1, op_daddr}] = op_wval;
        endcase
        op_active = 1'b0;
        ops_done++;
      end
      if (h_pending) begin
        if (host_gnt) begin
          check("rnd_host_wait_bound", 32'(h_wait <= 3 * HMW + 2), 1);
          if (h_we) begin
`ifdef BF_MEM_PROTECT_EN
            if (!(run && !h_addr[8])) ref_mem[h_addr] = h_wdata;
`else
            ref_mem[h_addr] = h_wdata;
`endif
          end else begin
            exp_rv = 1'b1;
            exp_rd = ref_mem[h_addr];
          end
          h_pending = 1'b0;
          h_done++;
        end else begin
          h_wait++;
        end
      end else begin
        check("rnd_gnt_without_req", 32'(host_gnt), 0);
      end
    end
    check("rnd_core_progress", 32'(ops_done > 300), 1);
    check("rnd_host_progress", 32'(h_done > 100), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
